usb_tx_bitstuffer: RTL

//  Byte-to-bit serializer with USB bit stuffing; sits directly upstream of the NRZI/line-state transmitter.

---
 rtl/usb_pkg.sv | 16 +
 rtl/usb_tx_bitstuffer_if.sv | 12 +
 rtl/usb_bit_stuffer.sv | 33 +++
 rtl/usb_tx_bitstuffer.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// Shared types and defaults for the USB transmit bit-stuffer.
package usb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_STUFF,
    ST_GAP
  } state_e;

  localparam int unsigned STUFF_LEN_DEF    = 6;
  localparam logic [7:0]  SYNC_PATTERN_DEF = 8'h80;
  localparam int unsigned GAP_CYCLES_DEF   = 4;

endpackage

// File: rtl/usb_tx_bitstuffer_if.sv
// Byte-side valid/ready handshake between the packet source and the serializer.
interface usb_tx_bitstuffer_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_last;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, output tx_last, input tx_ready);
  modport slave  (input tx_data, input tx_valid, input tx_last, output tx_ready);

endinterface

// File: rtl/usb_bit_stuffer.sv
// Tracks the run of 1s on the outgoing serial stream and requests a stuffed 0.
module usb_bit_stuffer #(
  parameter int unsigned STUFF_LEN = usb_pkg::STUFF_LEN_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic bit_i,
  input  logic val_i,
  output logic stall_req_o
);

  localparam int unsigned W = $clog2(STUFF_LEN + 1);

  logic [W-1:0] ones_cnt_q, ones_cnt_d;

  // Saturating so a long run of 1s in a non-stuffed region cannot wrap.
  always_comb begin
    ones_cnt_d = ones_cnt_q;
    if (!val_i || !bit_i) begin
      ones_cnt_d = '0;
    end else if (ones_cnt_q != W'(STUFF_LEN)) begin
      ones_cnt_d = ones_cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ones_cnt_q <= '0;
    else     ones_cnt_q <= ones_cnt_d;
  end

  assign stall_req_o = (ones_cnt_q == W'(STUFF_LEN));

endmodule

// File: rtl/usb_tx_bitstuffer.sv
// Byte-to-bit serializer with USB bit stuffing, LSB first, one bit per clk.
// Define USB_TX_SYNC_EN to prepend SYNC_PATTERN to every packet.
module usb_tx_bitstuffer
  import usb_pkg::*;
#(
  parameter int unsigned STUFF_LEN    = STUFF_LEN_DEF,
  parameter logic [7:0]  SYNC_PATTERN = SYNC_PATTERN_DEF,
  parameter int unsigned GAP_CYCLES   = GAP_CYCLES_DEF
) (
  input  logic                clk,
  input  logic                rst,
  usb_tx_bitstuffer_if.slave  tx_bus,
  output logic                s_data_out,
  output logic                s_data_val,
  output logic                busy,
  output logic                underrun
);

`ifdef USB_TX_SYNC_EN
  localparam bit SyncEn = 1'b1;
`else
  localparam bit SyncEn = 1'b0;
`endif

  localparam int unsigned GW = $clog2(GAP_CYCLES + 1);

  state_e          state_q, state_d;
  logic [7:0]      sh_q, sh_d;
  logic            last_q, last_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
  logic [7:0]      hold_data_q, hold_data_d;
  logic            hold_last_q, hold_last_d;
  logic            hold_full_q, hold_full_d;
  logic            tx_ready_q;
  logic            out_q, out_d, val_q, val_d, busy_q, underrun_q, underrun_d;
  logic            pull, accept, stall_req;

  assign accept = tx_bus.tx_valid & tx_ready_q;

  // A pull and an accept on the same edge reload the holding register.
  always_comb begin
    hold_full_d = hold_full_q & ~pull;
    hold_data_d = hold_data_q;
    hold_last_d = hold_last_q;
    if (accept) begin
      hold_full_d = 1'b1;
      hold_data_d = tx_bus.tx_data;
      hold_last_d = tx_bus.tx_last;
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    last_d     = last_q;
    bit_cnt_d  = bit_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    out_d      = 1'b0;
    val_d      = 1'b0;
    underrun_d = 1'b0;
    pull       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (hold_full_q) begin
          val_d     = 1'b1;
          bit_cnt_d = 3'd1;
          if (SyncEn) begin
            state_d = ST_SYNC;
            sh_d    = SYNC_PATTERN;
            last_d  = 1'b0;
            out_d   = SYNC_PATTERN[0];
          end else begin
            state_d = ST_DATA;
            pull    = 1'b1;
            sh_d    = hold_data_q;
            last_d  = hold_last_q;
            out_d   = hold_data_q[0];
          end
        end
      end
      ST_SYNC, ST_DATA, ST_STUFF: begin
        // A pending stuff bit wins over the byte-boundary decision.
        if (state_q != ST_SYNC && stall_req) begin
          state_d = ST_STUFF;
          val_d   = 1'b1;
        end else if (bit_cnt_q != 3'd0) begin
          if (state_q == ST_STUFF) state_d = ST_DATA;
          val_d     = 1'b1;
          out_d     = sh_q[bit_cnt_q];
          bit_cnt_d = bit_cnt_q + 3'd1;
        end else if (last_q) begin
          state_d   = ST_GAP;
          gap_cnt_d = '0;
        end else if (hold_full_q) begin
          state_d   = ST_DATA;
          pull      = 1'b1;
          sh_d      = hold_data_q;
          last_d    = hold_last_q;
          val_d     = 1'b1;
          out_d     = hold_data_q[0];
          bit_cnt_d = 3'd1;
        end else begin
          state_d    = ST_GAP;
          gap_cnt_d  = '0;
          underrun_d = 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GW'(GAP_CYCLES - 1)) begin
          state_d   = ST_IDLE;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  usb_bit_stuffer #(.STUFF_LEN(STUFF_LEN)) u_stuffer (
    .clk         (clk),
    .rst         (rst),
    .bit_i       (out_d),
    .val_i       (val_d),
    .stall_req_o (stall_req)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sh_q        <= '0;
      last_q      <= 1'b0;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      hold_data_q <= '0;
      hold_last_q <= 1'b0;
      hold_full_q <= 1'b0;
      tx_ready_q  <= 1'b0;
      out_q       <= 1'b0;
      val_q       <= 1'b0;
      busy_q      <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      last_q      <= last_d;
      bit_cnt_q   <= bit_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      hold_data_q <= hold_data_d;
      hold_last_q <= hold_last_d;
      hold_full_q <= hold_full_d;
      tx_ready_q  <= ~hold_full_d;
      out_q       <= out_d;
      val_q       <= val_d;
      busy_q      <= (state_d != ST_IDLE);
      underrun_q  <= underrun_d;
    end
  end

  assign tx_bus.tx_ready = tx_ready_q;
  assign s_data_out      = out_q;
  assign s_data_val      = val_q;
  assign busy            = busy_q;
  assign underrun        = underrun_q;

endmodule
